// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: four-way write arbiter and sequencer for a shared
// WIDTH-bit D-register. Grants one requester, drives reg_en/reg_d for HOLD
// cycles, then pulses a one-cycle ack.
// Configuration macro REG_WRITE_ARB_FIXED_PRIORITY_EN: when defined, the
// lowest-index request always wins; when undefined, round-robin from last+1.
module reg_write_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   d_in,
    output logic [3:0]           grant,
    output logic [3:0]           ack,
    output logic                 reg_en,
    output logic [WIDTH-1:0]     reg_d,
    output logic [WIDTH-1:0]     q,
    output logic                 busy
);

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   reg_en_q, reg_en_d;
    logic                   busy_q, busy_d;
    logic [WIDTH-1:0]       reg_d_q, reg_d_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   win_vld;
    logic [IDX_W-1:0]       win_idx;
    logic [WIDTH-1:0]       win_data;

`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       cand;
`endif

    // Winner selection: scan order is the only difference between builds.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
`ifdef REG_WRITE_ARB_FIXED_PRIORITY_EN
        // Descending scan so the lowest asserted index is the last to write.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
`else
        cand = '0;
        // Scan last+4 down to last+1 so the first hit after last wins.
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            cand = last_q + IDX_W'(i);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
`endif
    end

    // Select the winning requester's data lane.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = d_in[i*WIDTH +: WIDTH];
            end
        end
    end

`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
    // Encode the one-hot grant back to an index for the round-robin pointer.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state and next-output logic; outputs follow the next state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        reg_d_d = reg_d_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    reg_d_d = win_data;
                    cnt_d   = CNT_W'(HOLD - 1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                q_d = reg_d_q;
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
                last_d  = grant_idx;
`endif
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        reg_en_d = (state_d == LOAD);
        busy_d   = (state_d != IDLE);
        ack_d    = (state_d == ACK) ? grant_d : '0;
    end

    // State and output registers; reset abandons any transfer without ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            reg_en_q <= 1'b0;
            busy_q   <= 1'b0;
            reg_d_q  <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
            last_q   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            reg_en_q <= reg_en_d;
            busy_q   <= busy_d;
            reg_d_q  <= reg_d_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
`ifndef REG_WRITE_ARB_FIXED_PRIORITY_EN
            last_q   <= last_d;
`endif
        end
    end

    assign grant  = grant_q;
    assign ack    = ack_q;
    assign reg_en = reg_en_q;
    assign busy   = busy_q;
    assign reg_d  = reg_d_q;
    assign q      = q_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: transaction-timed reference model compared every
// cycle, directed literal checks, random traffic, and HOLD=1/15 timing instances.
`timescale 1ns/1ps
module tb_reg_write_arbiter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HOLD   = 2;
    localparam int          HOLD_I = int'(HOLD);
`ifdef REG_WRITE_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         req = 4'b0;
    logic [4*WIDTH-1:0] d_in = '0;
    logic [3:0]         grant, ack;
    logic               reg_en, busy;
    logic [WIDTH-1:0]   reg_d, q;

    logic               rst_s = 1'b1;
    logic [3:0]         req_s = 4'hF;
    logic [4*WIDTH-1:0] d_s = 32'h1234_5678;
    logic [3:0]         g1, a1, g15, a15;
    logic               en1, en15, b1, b15;
    logic [WIDTH-1:0]   rd1, q1, rd15, q15;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit sw_en  = 1'b0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in), .grant(grant), .ack(ack),
        .reg_en(reg_en), .reg_d(reg_d), .q(q), .busy(busy));

    reg_write_arbiter #(.WIDTH(WIDTH), .HOLD(1)) u_h1 (
        .clk(clk), .rst(rst_s), .req(req_s), .d_in(d_s), .grant(g1), .ack(a1),
        .reg_en(en1), .reg_d(rd1), .q(q1), .busy(b1));

    reg_write_arbiter #(.WIDTH(WIDTH), .HOLD(15)) u_h15 (
        .clk(clk), .rst(rst_s), .req(req_s), .d_in(d_s), .grant(g15), .ack(a15),
        .reg_en(en15), .reg_d(rd15), .q(q15), .busy(b15));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner from the arbitration rule: circular scan starting at last+1 (or 0).
    function automatic int pick(input logic [3:0] r, input int last);
        int start;
        start = FIXED ? 0 : (last + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    // Reference model: m_t counts cycles since the grant edge, -1 when idle.
    int               m_t    = -1;
    int               m_win  = 0;
    int               m_last = 3;
    logic [WIDTH-1:0] m_data = '0;
    logic [WIDTH-1:0] m_q    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t    <= -1;
            m_win  <= 0;
            m_last <= 3;
            m_data <= '0;
            m_q    <= '0;
        end else if (m_t >= 0) begin
            if (m_t < HOLD_I) m_q <= m_data;
            if (m_t == HOLD_I) begin
                m_last <= m_win;
                m_t    <= -1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (req != 4'b0) begin
            m_win  <= pick(req, m_last);
            m_data <= WIDTH'(d_in >> (pick(req, m_last) * int'(WIDTH)));
            m_t    <= 0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        logic [3:0] eg;
        if (chk_en) begin
            eg = (m_t >= 0) ? 4'(1 << m_win) : 4'b0;
            chk("grant",  32'(grant),  32'(eg));
            chk("ack",    32'(ack),    32'((m_t == HOLD_I) ? eg : 4'b0));
            chk("reg_en", 32'(reg_en), 32'(m_t >= 0 && m_t < HOLD_I));
            chk("busy",   32'(busy),   32'(m_t >= 0));
            chk("reg_d",  32'(reg_d),  32'(m_data));
            chk("q",      32'(q),      32'(m_q));
        end
    end

    // HOLD=1 and HOLD=15 instances under continuous requests: enable length and ack spacing.
    int cyc_n = 0;
    int run1 = 0, run15 = 0;
    int lack1 = -1, lack15 = -1;
    always @(negedge clk) begin
        cyc_n++;
        if (sw_en) begin
            if (en1) run1++;
            else if (run1 != 0) begin chk("h1_en_len", 32'(run1), 32'd1); run1 = 0; end
            if (en15) run15++;
            else if (run15 != 0) begin chk("h15_en_len", 32'(run15), 32'd15); run15 = 0; end
            if (a1 != 4'b0) begin
                if (lack1 >= 0) chk("h1_ack_gap", 32'(cyc_n - lack1), 32'd3);
                lack1 = cyc_n;
            end
            if (a15 != 4'b0) begin
                if (lack15 >= 0) chk("h15_ack_gap", 32'(cyc_n - lack15), 32'd17);
                lack15 = cyc_n;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Wait (bounded) until grant is nonzero (want=1) or zero (want=0).
    task automatic wait_grant(input bit want);
        int k;
        k = 0;
        while (((grant != 4'b0) != want) && k < 40) begin
            cyc(1);
            k++;
        end
        checks++;
        if (k >= 40) begin
            errors++;
            $display("FAIL wait_grant timeout want=%0d grant=%b", want, grant);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        cyc(2);
        rst   = 1'b0;
        rst_s = 1'b0;
        sw_en = 1'b1;
        chk_en = 1'b1;

        // Reset state literals
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_q",     32'(q),     32'd0);
        chk("rst_reg_en", 32'(reg_en), 32'd0);

        // Single request from requester 2
        req  = 4'b0100;
        d_in = 32'h00A5_0000;
        cyc(1);
        chk("t1_grant", 32'(grant), 32'h4);
        chk("t1_en0",   32'(reg_en), 32'd1);
        req = 4'b0;
        cyc(1);
        chk("t1_en1", 32'(reg_en), 32'd1);
        chk("t1_q",   32'(q), 32'hA5);
        cyc(1);
        chk("t1_ack", 32'(ack), 32'h4);
        chk("t1_en2", 32'(reg_en), 32'd0);
        cyc(1);
        chk("t1_ack_off", 32'(ack), 32'd0);
        chk("t1_busy",    32'(busy), 32'd0);

        // Fairness under continuous requests
        do_reset();
        req = 4'hF;
        for (int n = 0; n < 16; n++) begin
            wait_grant(1'b1);
            exp_g = FIXED ? 4'b0001 : 4'(1 << (n % 4));
            chk("rr_order", 32'(grant), 32'(exp_g));
            wait_grant(1'b0);
        end
        req = 4'b0;

        // Data freeze: lane change during LOAD is ignored
        d_in = 32'h0000_3C00;
        req  = 4'b0010;
        wait_grant(1'b1);
        chk("freeze_grant", 32'(grant), 32'h2);
        d_in = 32'h0000_FF00;
        req  = 4'b0;
        wait_grant(1'b0);
        chk("freeze_q", 32'(q), 32'h3C);

        // Withdrawal of req[2] after its grant
        req = 4'b1110;
        wait_grant(1'b1);
        chk("wd_grant", 32'(grant), FIXED ? 32'h2 : 32'h4);
        req = 4'b1010;
        wait_grant(1'b0);
        wait_grant(1'b1);
        chk("wd_next", 32'(grant), FIXED ? 32'h2 : 32'h8);
        req = 4'b0;
        wait_grant(1'b0);

        // Reset during the second LOAD cycle
        d_in = 32'h77_66_55_44;
        req  = 4'b1001;
        wait_grant(1'b1);
        cyc(1);
        rst = 1'b1;
        #1;
        chk("mid_grant",  32'(grant),  32'd0);
        chk("mid_reg_en", 32'(reg_en), 32'd0);
        chk("mid_q",      32'(q),      32'd0);
        chk("mid_busy",   32'(busy),   32'd0);
        chk("mid_ack",    32'(ack),    32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("mid_regrant", 32'(grant), 32'h1);
        req = 4'b0;
        wait_grant(1'b0);

        // Random traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            d_in = 32'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc(1);
        end
        req = 4'b0;
        wait_grant(1'b0);
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
